// File: rtl/phy_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : phy_tx_scheduler
//  Function : Round-robin, burst-bounded scheduler that multiplexes four
//             show-ahead word FIFOs onto the PHY transmitter word input.
//  Revision : 1.0 - initial release
// ============================================================================
module phy_tx_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic [3:0]            fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_0,
    input  logic [DATA_WIDTH-1:0] fifo_data_1,
    input  logic [DATA_WIDTH-1:0] fifo_data_2,
    input  logic [DATA_WIDTH-1:0] fifo_data_3,
    input  logic                  pause,
    output logic [3:0]            fifo_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            grant_ch,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam logic [3:0] C_BURST_LAST = 4'(BURST_MAX - 1);

    state_t                r_state;
    logic [1:0]            r_last;
    logic [3:0]            r_burst_cnt;
    logic [1:0]            r_grant;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    logic [1:0]            w_sel;
    logic [1:0]            w_probe;
    logic                  w_req;
    logic                  w_can_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // First non-empty channel after the last one served, wrapping mod 4.
    always_comb begin
        w_req   = 1'b0;
        w_sel   = r_last;
        w_probe = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_probe = r_last + k[1:0];
            if (!w_req && !fifo_empty[w_probe]) begin
                w_req = 1'b1;
                w_sel = w_probe;
            end
        end
    end

    always_comb begin
        w_head = fifo_data_0;
        case (r_grant)
            2'd0:    w_head = fifo_data_0;
            2'd1:    w_head = fifo_data_1;
            2'd2:    w_head = fifo_data_2;
            default: w_head = fifo_data_3;
        endcase
    end

    assign w_can_pop = (r_state == ST_SERVE) && !pause && !fifo_empty[r_grant];

    always_comb begin
        fifo_pop = 4'b0000;
        if (w_can_pop) begin
            fifo_pop = 4'b0001 << r_grant;
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 2'd3;
            r_burst_cnt <= 4'd0;
            r_grant     <= 2'd0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_req) begin
                        r_grant     <= w_sel;
                        r_burst_cnt <= 4'd0;
                        r_state     <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (pause) begin
                        r_valid <= 1'b0;
                    end else if (!fifo_empty[r_grant]) begin
                        r_data  <= w_head;
                        r_valid <= 1'b1;
                        // Counter saturates at the burst limit; the next grant clears it.
                        if (r_burst_cnt == C_BURST_LAST) begin
                            r_last  <= r_grant;
                            r_state <= ST_IDLE;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 4'd1;
                        end
                    end else begin
                        r_valid <= 1'b0;
                        r_last  <= r_grant;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign grant_ch  = r_grant;
    assign busy      = (r_state == ST_SERVE);

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phy_tx_scheduler
//  Function : Scoreboard bench for phy_tx_scheduler with a show-ahead FIFO model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phy_tx_scheduler;

    logic        clk_2f      = 1'b0;
    logic        reset       = 1'b1;
    logic [3:0]  fifo_empty  = 4'hF;
    logic [31:0] fifo_data_0 = 32'h0;
    logic [31:0] fifo_data_1 = 32'h0;
    logic [31:0] fifo_data_2 = 32'h0;
    logic [31:0] fifo_data_3 = 32'h0;
    logic        pause       = 1'b0;
    logic [3:0]  fifo_pop;
    logic [31:0] data_out;
    logic        valid_out;
    logic [1:0]  grant_ch;
    logic        busy;

    phy_tx_scheduler #(.DATA_WIDTH(32), .BURST_MAX(4)) dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_data_0 (fifo_data_0),
        .fifo_data_1 (fifo_data_1),
        .fifo_data_2 (fifo_data_2),
        .fifo_data_3 (fifo_data_3),
        .pause       (pause),
        .fifo_pop    (fifo_pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .grant_ch    (grant_ch),
        .busy        (busy)
    );

    always #5 clk_2f = ~clk_2f;

    logic [31:0] fq [4][$];
    logic [33:0] exp_word [$];
    int          exp_run [$];
    int          exp_gap [$];
    int          exp_burst [$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_to   = 0;
    logic        mon_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    // Show-ahead FIFO model: pops what the DUT strobed at the edge it was sampled.
    initial begin : fifo_model
        logic [3:0] pend;
        logic       rst_at_edge;
        forever begin
            @(negedge clk_2f);
            pend = fifo_pop;
            @(posedge clk_2f);
            rst_at_edge = reset;
            #2;
            for (int ch = 0; ch < 4; ch++) begin
                if (rst_at_edge && pend[ch] && fq[ch].size() > 0) void'(fq[ch].pop_front());
            end
            for (int ch = 0; ch < 4; ch++) fifo_empty[ch] = (fq[ch].size() == 0);
            fifo_data_0 = (fq[0].size() > 0) ? fq[0][0] : 32'hDEAD_BEEF;
            fifo_data_1 = (fq[1].size() > 0) ? fq[1][0] : 32'hDEAD_BEEF;
            fifo_data_2 = (fq[2].size() > 0) ? fq[2][0] : 32'hDEAD_BEEF;
            fifo_data_3 = (fq[3].size() > 0) ? fq[3][0] : 32'hDEAD_BEEF;
        end
    end

    initial begin : monitor
        logic       prev_valid;
        logic       prev_busy;
        logic       hi_seen;
        logic [1:0] prev_grant;
        logic [33:0] ew;
        int         run;
        int         gap;
        int         pops;
        int         g;
        prev_valid = 1'b0; prev_busy = 1'b0; hi_seen = 1'b0; prev_grant = 2'd0;
        run = 0; gap = 0; pops = 0;
        forever begin
            @(negedge clk_2f or negedge reset);
            if (!reset) begin
                #1;
                if (hi_seen) begin
                    chk("async_rst_valid", valid_out, 0);
                    chk("async_rst_pop",   fifo_pop,  0);
                    chk("async_rst_busy",  busy,      0);
                    chk("async_rst_data",  data_out,  0);
                end else begin
                    chk("rst_valid", valid_out, 0);
                    chk("rst_pop",   fifo_pop,  0);
                    chk("rst_busy",  busy,      0);
                    chk("rst_data",  data_out,  0);
                    chk("rst_grant", grant_ch,  0);
                end
                hi_seen = 1'b0; prev_valid = 1'b0; prev_busy = 1'b0;
                run = 0; gap = 0; pops = 0;
            end else if (!mon_en) begin
                hi_seen = 1'b1; prev_valid = 1'b0; prev_busy = 1'b0;
                run = 0; gap = 0; pops = 0;
            end else begin
                hi_seen = 1'b1;
                if (valid_out) begin
                    if (!prev_valid) begin
                        if (exp_gap.size() > 0) begin
                            g = exp_gap.pop_front();
                            if (g >= 0) chk("gap_len", gap, g);
                        end
                    end
                    if (exp_word.size() == 0) begin
                        n_chk++;
                        $display("FAIL word: got unexpected 0x%0h on ch%0d, required none", data_out, grant_ch);
                    end else begin
                        ew = exp_word.pop_front();
                        chk("data",  data_out, ew[31:0]);
                        chk("grant", grant_ch, ew[33:32]);
                    end
                    run++;
                end else begin
                    if (prev_valid) begin
                        if (exp_run.size() == 0) begin
                            n_chk++;
                            $display("FAIL run_len: got unexpected run of %0d, required none", run);
                        end else begin
                            chk("run_len", run, exp_run.pop_front());
                        end
                        run = 0;
                        gap = 0;
                    end
                    gap++;
                end
                if (!busy) chk("pop_idle", fifo_pop, 0);
                else if (fifo_pop != 4'b0) chk("pop_onehot", fifo_pop, 4'b0001 << grant_ch);
                if (pause) chk("pop_paused", fifo_pop, 0);
                if (prev_busy && busy) chk("grant_hold", grant_ch, prev_grant);
                if (busy && fifo_pop != 4'b0) pops++;
                if (prev_busy && !busy) begin
                    if (exp_burst.size() == 0) begin
                        n_chk++;
                        $display("FAIL burst_len: got unexpected burst of %0d, required none", pops);
                    end else begin
                        chk("burst_len", pops, exp_burst.pop_front());
                    end
                    pops = 0;
                end
                prev_valid = valid_out;
                prev_busy  = busy;
                prev_grant = grant_ch;
            end
        end
    end

    task automatic push(input int ch, input logic [31:0] v);
        fq[ch].push_back(v);
        exp_word.push_back({2'(ch), v});
    endtask

    task automatic expect_only(input int ch, input logic [31:0] v);
        exp_word.push_back({2'(ch), v});
    endtask

    task automatic expect_burst(input int len, input int gap);
        exp_run.push_back(len);
        exp_gap.push_back(gap);
        exp_burst.push_back(len);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_word.size() != 0 || exp_run.size() != 0 || exp_burst.size() != 0 ||
                busy || valid_out) && t < 300) begin
            @(posedge clk_2f); #1;
            t++;
        end
        if (t >= 300) begin
            n_to++;
            $display("FAIL %s: drain timeout, got %0d words pending, required 0", name, exp_word.size());
            exp_word.delete(); exp_run.delete(); exp_gap.delete(); exp_burst.delete();
        end
        exp_gap.delete();
        repeat (3) @(posedge clk_2f);
        #1;
    endtask

    task automatic wait_pops(input int ch, input int n, input string name);
        int cnt;
        int t;
        cnt = 0; t = 0;
        while (cnt < n && t < 60) begin
            @(negedge clk_2f);
            if (fifo_pop[ch]) cnt++;
            t++;
        end
        if (cnt < n) begin
            n_to++;
            $display("FAIL %s: got %0d pops, required %0d", name, cnt, n);
        end
    endtask

    initial begin : stimulus
        // Reset with every FIFO holding data; channel 0 must win first.
        #1 reset = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            push(ch, 32'hA000_0000 | 32'(ch));
            expect_burst(1, -1);
        end
        repeat (3) @(posedge clk_2f);
        #1 reset = 1'b1;
        wait_drain("reset_order");

        // Round robin, 6 words each: bursts 4,4,4,4 then 2,2,2,2.
        for (int ch = 0; ch < 4; ch++)
            for (int i = 0; i < 6; i++) fq[ch].push_back((32'(ch + 1) << 28) | 32'(i));
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < 4; ch++) begin
                for (int i = 0; i < (r == 0 ? 4 : 2); i++)
                    expect_only(ch, (32'(ch + 1) << 28) | 32'(r * 4 + i));
                if (r == 0) expect_burst(4, (ch == 0) ? -1 : 1);
                else        expect_burst(2, (ch == 0) ? 1 : -1);
            end
        end
        wait_drain("round_robin");

        // Single channel, short burst.
        push(1, 32'hFFFF_FFFF);
        push(1, 32'hEEEE_EEEE);
        push(1, 32'hDDDD_DDDD);
        expect_burst(3, -1);
        wait_drain("single_ch1");

        // Lone requester split into 4,4,2.
        for (int i = 1; i <= 10; i++) push(2, 32'(i));
        expect_burst(4, -1);
        expect_burst(4, 1);
        expect_burst(2, 1);
        wait_drain("lone_ch2");

        // Pause for two cycles after the second pop of a ch0 burst.
        for (int i = 0; i < 4; i++) push(0, 32'hC0DE_0000 | 32'(i));
        exp_run.push_back(2); exp_gap.push_back(-1);
        exp_run.push_back(2); exp_gap.push_back(2);
        exp_burst.push_back(4);
        wait_pops(0, 2, "pause_wait");
        @(posedge clk_2f); #1 pause = 1'b1;
        @(posedge clk_2f);
        @(posedge clk_2f); #1 pause = 1'b0;
        wait_drain("pause_ch0");

        // Asynchronous reset during the second word of a ch3 burst.
        mon_en = 1'b0;
        for (int i = 1; i <= 4; i++) fq[3].push_back(32'h3333_0000 | 32'(i));
        wait_pops(3, 2, "rst_mid_wait");
        #2 reset = 1'b0;
        repeat (2) @(posedge clk_2f);
        #1;
        mon_en = 1'b1;
        push(0, 32'h0000_AAAA);
        for (int i = 2; i <= 4; i++) expect_only(3, 32'h3333_0000 | 32'(i));
        expect_burst(1, -1);
        expect_burst(3, -1);
        repeat (2) @(posedge clk_2f);
        #1 reset = 1'b1;
        wait_drain("rst_mid_burst");

        $display("%0d/%0d checks passed", n_pass, n_chk + n_to);
        $finish;
    end

endmodule
`default_nettype wire
